// File: rtl/video_timing_pkg.sv
// Shared timing constants and sync polarity encoding for the raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package video_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int CNT_W  = 10;
   localparam int DIV_W  = 2;
   localparam int LINE_W = 9;

   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   // Drive the active level inside the sync window, the idle level elsewhere.
   function automatic logic sync_level(input logic in_window, input sync_pol_e pol);
      return in_window ? logic'(pol) : ~logic'(pol);
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping position counter plus next-position window decode.
// The next-state position is exported so the parent can register its outputs in step.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int TOTAL      = DEF_H_TOTAL,
   parameter int ACTIVE     = DEF_H_ACTIVE,
   parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
   parameter int SYNC_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   output logic [CNT_W-1:0] cnt_d,
   output logic             wrap,
   output logic             active_d,
   output logic             sync_d
);

   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      wrap  = step && (cnt_q == CNT_W'(TOTAL - 1));
      cnt_d = cnt_q;
      if (step) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      active_d = (cnt_d < CNT_W'(ACTIVE));
      sync_d   = (cnt_d >= CNT_W'(SYNC_START)) && (cnt_d < CNT_W'(SYNC_END));
   end

   // Parked on the last position so the first step lands on zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= CNT_W'(TOTAL - 1);
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: composer strobes plus VGA sync / data enable.
// Every output is registered from the next-state counters, so it moves with them.
module video_timing
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int PIX_DIV  = 1,
   parameter int SYNC_POL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [LINE_W-1:0] display_line_idx,
   output logic              display_start_of_screen,
   output logic              display_start_of_line,
   output logic              display_next_pixel,
   output logic              display_active,
   output logic              vga_hsync,
   output logic              vga_vsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam sync_pol_e POL = sync_pol_e'(SYNC_POL[0]);
   localparam logic SYNC_IDLE = ~logic'(POL);

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              pix_en;
   logic [CNT_W-1:0]  h_cnt_d, v_cnt_d, next_line;
   logic              h_wrap, v_wrap;
   logic              h_active, v_active, h_sync, v_sync;

   logic [LINE_W-1:0] line_idx_q, line_idx_d;
   logic              sos_q, sos_d, sol_q, sol_d, next_pix_q, next_pix_d;
   logic              active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;

   always_comb begin
      pix_en    = enable && (div_cnt_q == DIV_W'(PIX_DIV - 1));
      div_cnt_d = div_cnt_q;
      if (enable) begin
         div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);
      end
   end

   timing_axis #(
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
   ) u_h_axis (
      .clk      (clk),
      .rst      (rst),
      .step     (pix_en),
      .cnt_d    (h_cnt_d),
      .wrap     (h_wrap),
      .active_d (h_active),
      .sync_d   (h_sync)
   );

   timing_axis #(
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
   ) u_v_axis (
      .clk      (clk),
      .rst      (rst),
      .step     (h_wrap),
      .cnt_d    (v_cnt_d),
      .wrap     (v_wrap),
      .active_d (v_active),
      .sync_d   (v_sync)
   );

   always_comb begin
      sol_d      = pix_en && (h_cnt_d == '0);
      sos_d      = v_wrap;
      next_pix_d = pix_en && h_active && v_active;
      active_d   = enable && h_active && v_active;
      hsync_d    = sync_level(enable && h_sync, POL);
      vsync_d    = sync_level(enable && v_sync, POL);

      // Renderers run one line ahead: report the line that follows the new one.
      next_line  = (v_cnt_d == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_d + CNT_W'(1);
      line_idx_d = line_idx_q;
      if (sol_d) begin
         line_idx_d = (next_line < CNT_W'(V_ACTIVE)) ? next_line[LINE_W-1:0] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q  <= '0;
         line_idx_q <= '0;
         sos_q      <= 1'b0;
         sol_q      <= 1'b0;
         next_pix_q <= 1'b0;
         active_q   <= 1'b0;
         hsync_q    <= SYNC_IDLE;
         vsync_q    <= SYNC_IDLE;
      end else begin
         div_cnt_q  <= div_cnt_d;
         line_idx_q <= line_idx_d;
         sos_q      <= sos_d;
         sol_q      <= sol_d;
         next_pix_q <= next_pix_d;
         active_q   <= active_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
      end
   end

   assign display_line_idx        = line_idx_q;
   assign display_start_of_screen = sos_q;
   assign display_start_of_line   = sol_q;
   assign display_next_pixel      = next_pix_q;
   assign display_active          = active_q;
   assign vga_hsync               = hsync_q;
   assign vga_vsync               = vsync_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: two small-raster instances (PIX_DIV 1 / active-low and
// PIX_DIV 2 / active-high) compared every clock against a position-arithmetic model.
module tb_video_timing;

   localparam int A_HA = 16, A_HFP = 4, A_HS = 6, A_HBP = 4;
   localparam int A_VA = 8,  A_VFP = 2, A_VS = 2, A_VBP = 3;
   localparam int A_DIV = 1, A_POL = 0;
   localparam int B_HA = 12, B_HFP = 3, B_HS = 5, B_HBP = 4;
   localparam int B_VA = 6,  B_VFP = 1, B_VS = 3, B_VBP = 2;
   localparam int B_DIV = 2, B_POL = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_a = 1'b0, en_b = 1'b0;

   logic [8:0] a_idx, b_idx;
   logic a_sos, a_sol, a_np, a_act, a_hs, a_vs;
   logic b_sos, b_sol, b_np, b_act, b_hs, b_vs;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   video_timing #(
      .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
      .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
      .PIX_DIV(A_DIV), .SYNC_POL(A_POL)
   ) dut_a (
      .clk(clk), .rst(rst), .enable(en_a),
      .display_line_idx(a_idx), .display_start_of_screen(a_sos),
      .display_start_of_line(a_sol), .display_next_pixel(a_np),
      .display_active(a_act), .vga_hsync(a_hs), .vga_vsync(a_vs)
   );

   video_timing #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
      .PIX_DIV(B_DIV), .SYNC_POL(B_POL)
   ) dut_b (
      .clk(clk), .rst(rst), .enable(en_b),
      .display_line_idx(b_idx), .display_start_of_screen(b_sos),
      .display_start_of_line(b_sol), .display_next_pixel(b_np),
      .display_active(b_act), .vga_hsync(b_hs), .vga_vsync(b_vs)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model state: enabled clocks since reset and the held line index.
   int         m_en_clks [2];
   logic [8:0] m_idx [2];

   // Position after s pixel steps since reset; s == 0 is the parked last pixel.
   task automatic model(input int inst, input bit r, input bit en, output logic [14:0] exp);
      int ha, hfp, hs, hbp, va, vfp, vs, vbp, dv, ht, vt, s, p, h, v, nl;
      bit pol, stepped, act, sol, sos, np, hsy, vsy;
      if (inst == 0) begin
         ha = A_HA; hfp = A_HFP; hs = A_HS; hbp = A_HBP;
         va = A_VA; vfp = A_VFP; vs = A_VS; vbp = A_VBP; dv = A_DIV; pol = 1'(A_POL);
      end else begin
         ha = B_HA; hfp = B_HFP; hs = B_HS; hbp = B_HBP;
         va = B_VA; vfp = B_VFP; vs = B_VS; vbp = B_VBP; dv = B_DIV; pol = 1'(B_POL);
      end
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      if (r) begin
         m_en_clks[inst] = 0;
         m_idx[inst] = '0;
         exp = {9'd0, 4'b0000, ~pol, ~pol};
      end else if (!en) begin
         exp = {m_idx[inst], 4'b0000, ~pol, ~pol};
      end else begin
         m_en_clks[inst]++;
         stepped = (m_en_clks[inst] % dv) == 0;
         s = m_en_clks[inst] / dv;
         if (s == 0) begin
            h = ht - 1;
            v = vt - 1;
         end else begin
            p = (s - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
         end
         act = (h < ha) && (v < va);
         sol = stepped && (h == 0);
         sos = sol && (v == 0);
         np  = stepped && act;
         hsy = (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol;
         vsy = (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol;
         if (sol) begin
            nl = (v + 1) % vt;
            m_idx[inst] = (nl < va) ? 9'(nl) : 9'd0;
         end
         exp = {m_idx[inst], sos, sol, np, act, hsy, vsy};
      end
   endtask

   task automatic cycle(input bit r, input bit ea, input bit eb);
      logic [14:0] exp_a, exp_b;
      rst  = r;
      en_a = ea;
      en_b = eb;
      @(posedge clk);
      #1;
      cyc++;
      model(0, r, ea, exp_a);
      model(1, r, eb, exp_b);
      check_val($sformatf("a_out@%0d", cyc), 32'({a_idx, a_sos, a_sol, a_np, a_act, a_hs, a_vs}), 32'(exp_a));
      check_val($sformatf("b_out@%0d", cyc), 32'({b_idx, b_sos, b_sol, b_np, b_act, b_hs, b_vs}), 32'(exp_b));
   endtask

   initial begin
      int a_sos_at[$], b_sos_at[$];
      int a_np_n, b_np_n, b_act_n, gap_bad, np_line, waited;
      bit got_sol;

      // Phase 1: free-running frames from reset.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
      a_np_n = 0; b_np_n = 0; b_act_n = 0;
      for (int i = 0; i < 1200; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         if (a_sos) a_sos_at.push_back(i);
         if (b_sos) b_sos_at.push_back(i);
         if (a_sos_at.size() == 1 && a_np) a_np_n++;
         if (b_sos_at.size() == 1 && b_np) b_np_n++;
         if (b_sos_at.size() == 1 && b_act) b_act_n++;
      end
      check_val("a_sos_count", 32'(a_sos_at.size() >= 2), 32'd1);
      check_val("b_sos_count", 32'(b_sos_at.size() >= 2), 32'd1);
      if (a_sos_at.size() >= 2) begin
         check_val("a_first_sos_clk", 32'(a_sos_at[0]), 32'd0);
         check_val("a_frame_period", 32'(a_sos_at[1] - a_sos_at[0]), 32'd450);
      end
      if (b_sos_at.size() >= 2) begin
         check_val("b_first_sos_clk", 32'(b_sos_at[0]), 32'd1);
         check_val("b_frame_period", 32'(b_sos_at[1] - b_sos_at[0]), 32'd576);
      end
      check_val("a_frame_strobes", 32'(a_np_n), 32'(A_HA * A_VA));
      check_val("b_frame_strobes", 32'(b_np_n), 32'(B_HA * B_VA));
      check_val("b_frame_active_clks", 32'(b_act_n), 32'(B_HA * B_VA * B_DIV));
      $display("phase free_run: %0d compared so far", n_cmp);

      // Phase 2: enable dropped for 50 clks mid visible line (A at line 2, h=8).
      cycle(1'b1, 1'b0, 1'b0);
      np_line = 0;
      for (int k = 0; k < 69; k++) begin
         cycle(1'b0, 1'b1, 1'b1);
         if (k >= 60 && a_np) np_line++;
      end
      gap_bad = 0;
      for (int k = 0; k < 50; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (a_np || a_sol || a_sos || a_act || a_hs !== 1'b1 || a_vs !== 1'b1) gap_bad++;
         if (b_np || b_sol || b_sos || b_act || b_hs !== 1'b0 || b_vs !== 1'b0) gap_bad++;
      end
      check_val("gap_quiet", 32'(gap_bad), 32'd0);
      got_sol = 1'b0;
      waited = 0;
      while (!got_sol && waited < 100) begin
         cycle(1'b0, 1'b1, 1'b1);
         waited++;
         if (a_sol) got_sol = 1'b1;
         else if (a_np) np_line++;
      end
      check_val("gap_line_end_seen", 32'(got_sol), 32'd1);
      check_val("gap_line_strobes", 32'(np_line), 32'(A_HA));
      $display("phase enable_gap: %0d compared so far", n_cmp);

      // Phase 3: reset mid-frame, then restart at (0,0).
      for (int k = 0; k < 137; k++) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      check_val("rst_mid_active", 32'({a_act, a_np, a_sol, b_act, b_np, b_sol}), 32'd0);
      cycle(1'b0, 1'b1, 1'b1);
      check_val("rst_restart_sos", 32'(a_sos), 32'd1);
      $display("phase mid_reset: %0d compared so far", n_cmp);

      // Phase 4: random enables with occasional resets.
      for (int k = 0; k < 4000; k++) begin
         cycle($urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      end
      $display("phase random: %0d compared so far", n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
